// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 VGA timing generator.
// The colour-bar constants and bar_colour() are consumed only when the
// test-pattern build option VGA_TIMING_TESTPATTERN_EN is defined.
package vga_pkg;

  // Default 640x480@60 timing (25.2 MHz pixel clock)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Coordinate widths of the registered timing record, sized for the default raster
  localparam int VGA_XW = $clog2(H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF);
  localparam int VGA_YW = $clog2(V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF);

  typedef struct packed {
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [VGA_XW-1:0] x;
    logic [VGA_YW-1:0] y;
  } vga_timing_t;

  // Colour-bar palette, left to right
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between the timing generator (master) and its
// consumers (slave). rgb exists only when VGA_TIMING_TESTPATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start;
  logic          line_start;
`ifdef VGA_TIMING_TESTPATTERN_EN
  logic [23:0]   rgb;

  modport master (output hsync, vsync, de, x, y, frame_start, line_start, rgb);
  modport slave  (input  hsync, vsync, de, x, y, frame_start, line_start, rgb);
`else
  modport master (output hsync, vsync, de, x, y, frame_start, line_start);
  modport slave  (input  hsync, vsync, de, x, y, frame_start, line_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping counter 0..MAX used for both raster axes. wrap_o is a
// combinational pulse, high in the cycle the counter moves from MAX to 0.
module vga_axis_counter #(
  parameter int MAX = 799,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == MAX_C);
  assign cnt_o  = cnt_q;

  // Next count: hold, increment, or wrap to zero at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default). All outputs are
// registered decodes of the h/v counters and so lag them by one clock.
// Define VGA_TIMING_TESTPATTERN_EN to add the 8-colour-bar rgb output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              in_clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  localparam logic [XW-1:0] H_ACT_C = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_ACT_C = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;

  vga_axis_counter #(.MAX(H_TOTAL - 1), .W(XW)) u_hcnt (
    .clk_i (in_clk), .rst_ni (rst_n), .en_i (1'b1),
    .cnt_o (h_cnt),  .wrap_o (h_wrap)
  );

  vga_axis_counter #(.MAX(V_TOTAL - 1), .W(YW)) u_vcnt (
    .clk_i (in_clk), .rst_ni (rst_n), .en_i (h_wrap),
    .cnt_o (v_cnt),  .wrap_o (v_wrap)
  );

  vga_timing_t timing_d, timing_q;
  logic        fs_d, fs_q;
  logic        ls_d, ls_q;

  // Decode the current counters into next-cycle output values
  always_comb begin
    timing_d       = '0;
    timing_d.de    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    timing_d.hsync = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    timing_d.vsync = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    timing_d.x     = timing_d.de ? VGA_XW'(h_cnt) : '0;
    timing_d.y     = timing_d.de ? VGA_YW'(v_cnt) : '0;
    fs_d           = (h_cnt == '0) && (v_cnt == '0);
    ls_d           = (h_cnt == '0) && (v_cnt < V_ACT_C);
  end

  // Output register; reset drives syncs inactive and everything else low
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      timing_q <= '{hsync: ~HS_POL, vsync: ~VS_POL, default: '0};
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      timing_q <= timing_d;
      fs_q     <= fs_d;
      ls_q     <= ls_d;
    end
  end

  // The vertical axis only advances on a horizontal wrap, so its wrap must coincide
  always_ff @(posedge in_clk) begin
    if (rst_n) assert (!v_wrap || h_wrap);
  end

  assign vga_o.hsync       = timing_q.hsync;
  assign vga_o.vsync       = timing_q.vsync;
  assign vga_o.de          = timing_q.de;
  assign vga_o.x           = XW'(timing_q.x);
  assign vga_o.y           = YW'(timing_q.y);
  assign vga_o.frame_start = fs_q;
  assign vga_o.line_start  = ls_q;

`ifdef VGA_TIMING_TESTPATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [23:0] rgb_d, rgb_q;

  // Bar index by threshold compare (avoids a divider), colour blanked outside de
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= XW'(k * BAR_W)) bar_idx = 3'(k);
    end
    rgb_d = timing_d.de ? bar_colour(bar_idx) : '0;
  end

  // Colour register aligned with de
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign vga_o.rgb = rgb_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance for
// reset, line timing, coordinates and mid-frame reset, plus a shrunken-raster
// instance (32x15 totals) so whole-frame timing fits in a short run.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_s_n;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(10)) vif ();
  vga_timing_gen_if #(.XW(5),  .YW(4))  sif ();

  vga_timing_gen dut (
    .in_clk (clk), .rst_n (rst_n), .vga_o (vif)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut_s (
    .in_clk (clk), .rst_n (rst_s_n), .vga_o (sif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          n;
    logic        de, hs, vs, ls, fs;
    int          x, y;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cur;
    int found;
    int de_cnt, de_first_low, hs_lo, hs_first, ls_between;
    int period, vs_lo, vs_first, sde_cnt, sls_cnt;

    // n = counter value (clocks since reset release) that the outputs reflect
    tbl.push_back('{0,    1, 1, 1, 1, 1, 0,   0, 24'hFFFFFF});
    tbl.push_back('{1,    1, 1, 1, 0, 0, 1,   0, 24'hFFFFFF});
    tbl.push_back('{80,   1, 1, 1, 0, 0, 80,  0, 24'hFFFF00});
    tbl.push_back('{400,  1, 1, 1, 0, 0, 400, 0, 24'hFF0000});
    tbl.push_back('{639,  1, 1, 1, 0, 0, 639, 0, 24'h000000});
    tbl.push_back('{640,  0, 1, 1, 0, 0, 0,   0, 24'h000000});
    tbl.push_back('{655,  0, 1, 1, 0, 0, 0,   0, 24'h000000});
    tbl.push_back('{656,  0, 0, 1, 0, 0, 0,   0, 24'h000000});
    tbl.push_back('{751,  0, 0, 1, 0, 0, 0,   0, 24'h000000});
    tbl.push_back('{752,  0, 1, 1, 0, 0, 0,   0, 24'h000000});
    tbl.push_back('{799,  0, 1, 1, 0, 0, 0,   0, 24'h000000});
    tbl.push_back('{800,  1, 1, 1, 1, 0, 0,   1, 24'hFFFFFF});
    tbl.push_back('{880,  1, 1, 1, 0, 0, 80,  1, 24'hFFFF00});
    tbl.push_back('{1439, 1, 1, 1, 0, 0, 639, 1, 24'h000000});
    tbl.push_back('{1440, 0, 1, 1, 0, 0, 0,   0, 24'h000000});

    // Reset held for ten clocks
    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (10) step();
    chk("rst_hsync", vif.hsync, 1);
    chk("rst_vsync", vif.vsync, 1);
    chk("rst_de",    vif.de, 0);
    chk("rst_x",     vif.x, 0);
    chk("rst_y",     vif.y, 0);
    chk("rst_fs",    vif.frame_start, 0);
    chk("rst_ls",    vif.line_start, 0);
    chk("rst_s_hsync", sif.hsync, 1);
    chk("rst_s_de",    sif.de, 0);
`ifdef VGA_TIMING_TESTPATTERN_EN
    chk("rst_rgb", vif.rgb, 0);
`endif

    // Table-driven vectors over the first two lines
    @(negedge clk);
    rst_n = 1'b1;
    cur = -1;
    foreach (tbl[i]) begin
      while (cur < tbl[i].n) begin
        step();
        cur++;
      end
      chk($sformatf("v%0d_de", tbl[i].n), vif.de, tbl[i].de);
      chk($sformatf("v%0d_hs", tbl[i].n), vif.hsync, tbl[i].hs);
      chk($sformatf("v%0d_vs", tbl[i].n), vif.vsync, tbl[i].vs);
      chk($sformatf("v%0d_ls", tbl[i].n), vif.line_start, tbl[i].ls);
      chk($sformatf("v%0d_fs", tbl[i].n), vif.frame_start, tbl[i].fs);
      chk($sformatf("v%0d_x",  tbl[i].n), vif.x, tbl[i].x);
      chk($sformatf("v%0d_y",  tbl[i].n), vif.y, tbl[i].y);
`ifdef VGA_TIMING_TESTPATTERN_EN
      chk($sformatf("v%0d_rgb", tbl[i].n), vif.rgb, tbl[i].rgb);
`endif
    end

    // Line timing measured from the next line_start
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      cur++;
      if (vif.line_start) begin
        found = 1;
        break;
      end
    end
    chk("line_start_found", found, 1);
    chk("line_start_at", cur, 1600);
    de_cnt = 1; de_first_low = -1; hs_lo = 0; hs_first = -1; ls_between = 0;
    for (int off = 1; off <= 800; off++) begin
      step();
      cur++;
      if (off < 800) begin
        if (vif.de) de_cnt++;
        else if (de_first_low < 0) de_first_low = off;
        if (!vif.hsync) begin
          hs_lo++;
          if (hs_first < 0) hs_first = off;
        end
        if (vif.line_start) ls_between++;
      end else begin
        chk("line_period_ls", vif.line_start, 1);
      end
    end
    chk("line_de_count",    de_cnt, 640);
    chk("line_de_low_at",   de_first_low, 640);
    chk("line_hs_low_cnt",  hs_lo, 96);
    chk("line_hs_low_at",   hs_first, 656);
    chk("line_ls_between",  ls_between, 0);

    // Mid-frame reset, asserted between clock edges while de is high
    chk("pre_rst_de", vif.de, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_de",    vif.de, 0);
    chk("async_rst_hsync", vif.hsync, 1);
    chk("async_rst_y",     vif.y, 0);
    chk("async_rst_ls",    vif.line_start, 0);
    repeat (3) begin
      step();
      chk("held_rst_fs", vif.frame_start, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart_fs", vif.frame_start, 1);
    chk("restart_de", vif.de, 1);
    chk("restart_x",  vif.x, 0);
    chk("restart_y",  vif.y, 0);
    step();
    chk("restart_x1", vif.x, 1);
    chk("restart_fs1", vif.frame_start, 0);

    // Whole-frame timing on the shrunken raster (32 x 15 = 480 clocks)
    @(negedge clk);
    rst_s_n = 1'b1;
    step();
    chk("s_first_fs", sif.frame_start, 1);
    period = -1; vs_lo = 0; vs_first = -1; sde_cnt = 1; sls_cnt = 1;
    for (int off = 1; off <= 1000; off++) begin
      step();
      if (sif.frame_start) begin
        period = off;
        break;
      end
      if (sif.de) sde_cnt++;
      if (sif.line_start) sls_cnt++;
      if (!sif.vsync) begin
        vs_lo++;
        if (vs_first < 0) vs_first = off;
      end
      if (off == 239) begin
        chk("s_last_px_de", sif.de, 1);
        chk("s_last_px_x",  sif.x, 15);
        chk("s_last_px_y",  sif.y, 7);
      end
      if (off == 240) begin
        chk("s_after_last_de", sif.de, 0);
        chk("s_after_last_x",  sif.x, 0);
        chk("s_after_last_y",  sif.y, 0);
      end
    end
    chk("s_frame_period", period, 480);
    chk("s_vsync_low_cnt", vs_lo, 64);
    chk("s_vsync_low_at", vs_first, 320);
    chk("s_de_count", sde_cnt, 128);
    chk("s_ls_count", sls_cnt, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
